// File: rtl/inst_mem_sync_if.sv
// Fetch and program-load signal bundle for inst_mem_sync.
// The master side is the fetch stage or loader; the slave side is the memory.
interface inst_mem_sync_if #(
    parameter int INST_W = 64,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 10
);
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic              stall;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              inst_err;
    logic              prog_we;
    logic [IDX_W-1:0]  prog_addr;
    logic [INST_W-1:0] prog_data;
    logic              busy;

    modport master (
        output ce, addr, stall, prog_we, prog_addr, prog_data,
        input  inst, inst_valid, inst_err, busy
    );

    modport slave (
        input  ce, addr, stall, prog_we, prog_addr, prog_data,
        output inst, inst_valid, inst_err, busy
    );
endinterface

// File: rtl/inst_mem_sync.sv
// Clocked, writable instruction memory with a registered 1-cycle fetch,
// stall hold, alignment/range checking, a program-load port and a post-reset clear sweep.
module inst_mem_sync #(
    parameter int INST_W       = 64,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 32,
    parameter int CLEAR_ON_RST = 1
) (
    input logic              clk,
    input logic              rst,
    inst_mem_sync_if.slave   bus
);
    localparam int OFF_W = $clog2(INST_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP_W = IDX_W + OFF_W;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  cnt_reg, cnt_next;
    logic              busy;

    logic [INST_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [INST_W-1:0] mem_wdata;

    logic [INST_W-1:0] inst_reg;
    logic              inst_valid_reg;
    logic              inst_err_reg;

    logic [IDX_W-1:0]  idx;
    logic              misaligned;
    logic              out_of_range;
    logic              fetch_hit;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign idx = bus.addr[TOP_W-1:OFF_W];

    generate
        if (OFF_W > 0) begin : g_off
            assign misaligned = |bus.addr[OFF_W-1:0];
        end else begin : g_no_off
            assign misaligned = 1'b0;
        end

        if (ADDR_W > TOP_W) begin : g_upper
            assign out_of_range = |bus.addr[ADDR_W-1:TOP_W];
        end else begin : g_no_upper
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Same-edge load to the fetched word is returned write-first.
    assign fetch_hit = bus.prog_we && (bus.prog_addr == idx);

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_we     = 1'b0;
        mem_waddr  = bus.prog_addr;
        mem_wdata  = bus.prog_data;
        case (state_reg)
            S_CLEAR: begin
                mem_we    = !rst;
                mem_waddr = cnt_reg;
                mem_wdata = '0;
                cnt_next  = cnt_reg + IDX_W'(1);
                if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                mem_we = bus.prog_we && !rst;
            end
        endcase
    end

    assign busy = (state_reg == S_CLEAR);

    // ------------------------------------------------------------------
    // Storage: single write port shared by the sweep and the loader
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered fetch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || busy) begin
            inst_reg       <= '0;
            inst_valid_reg <= 1'b0;
            inst_err_reg   <= 1'b0;
        end else if (!bus.stall) begin
            if (!bus.ce) begin
                inst_reg       <= '0;
                inst_valid_reg <= 1'b0;
                inst_err_reg   <= 1'b0;
            end else if (misaligned || out_of_range) begin
                inst_reg       <= '0;
                inst_valid_reg <= 1'b0;
                inst_err_reg   <= 1'b1;
            end else begin
                inst_reg       <= fetch_hit ? bus.prog_data : mem[idx];
                inst_valid_reg <= 1'b1;
                inst_err_reg   <= 1'b0;
            end
        end
    end

    assign bus.inst       = inst_reg;
    assign bus.inst_valid = inst_valid_reg;
    assign bus.inst_err   = inst_err_reg;
    assign bus.busy       = busy;
endmodule
